// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low with bit6=g down to bit0=a.
package seg_pkg;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Hex glyphs in active-low g..a order
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    // Position within a digit slot: blanking gap first, then lit
    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } phase_e;

    // Maps a 4-bit value onto its hex glyph
    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] glyph;
        glyph = SEG_BLANK;
        case (value)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            default: glyph = GLYPH_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer for the scan driver: counts cycles within a digit slot,
// steps the digit index, reports the slot phase and flags the last
// cycle of a frame. Disabling holds everything at digit 0, cycle 0.
module seg_slot_timer
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 16,
    parameter int DIG_W    = $clog2(N_DIGITS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    output logic [DIG_W-1:0] dig,
    output phase_e           phase,
    output logic             frame_end
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYC);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic             slot_end;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = en && slot_end && (dig_q == DIG_LAST);
    assign phase     = (cnt_q < CNT_GAP) ? GAP : SHOW;
    assign dig       = dig_q;

    // Advance the slot counter and digit index, wrapping at slot and frame ends
    always_comb begin
        cnt_d = cnt_q;
        dig_d = dig_q;
        if (!en) begin
            cnt_d = '0;
            dig_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner. Patterns are
// captured into a shadow buffer and copied to the displayed buffer only
// at frame boundaries so a frame never mixes old and new values.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP_CYC  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7*N_DIGITS-1:0] segIn,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   blankMask,
    input  logic                  en,
    output logic [N_DIGITS-1:0]   AN,
    output logic [6:0]            SEG,
    output logic                  frameDone
);

    localparam int DIG_W = $clog2(N_DIGITS);

    logic [N_DIGITS-1:0][6:0] seg_in_arr;
    logic [N_DIGITS-1:0][6:0] shadow_q, shadow_d;
    logic [N_DIGITS-1:0][6:0] active_q, active_d;
    logic                     pending_q, pending_d;
    logic [N_DIGITS-1:0]      an_q, an_d;
    logic [6:0]               seg_q, seg_d;
    logic                     frame_done_q, frame_done_d;

    logic [DIG_W-1:0] dig;
    phase_e           phase;
    logic             frame_end;

    assign seg_in_arr = segIn;

    seg_slot_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .GAP_CYC  (GAP_CYC),
        .DIG_W    (DIG_W)
    ) u_timer (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (en),
        .dig       (dig),
        .phase     (phase),
        .frame_end (frame_end)
    );

    // Double-buffer update: shadow follows load, active changes only at frame ends or while idle
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d = seg_in_arr;
        end
        if (!en) begin
            active_d  = load ? seg_in_arr : shadow_q;
            pending_d = 1'b0;
        end else if (frame_end) begin
            if (load) begin
                active_d = seg_in_arr;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Next output values from the current slot state, blanked in the gap, when masked or idle
    always_comb begin
        an_d         = '1;
        seg_d        = SEG_BLANK;
        frame_done_d = frame_end;
        if (en && (phase == SHOW) && !blankMask[dig]) begin
            an_d  = ~(N_DIGITS'(1) << dig);
            seg_d = active_q[dig];
        end
    end

    // Buffer and output registers, all returning to blank on reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q     <= {N_DIGITS{SEG_BLANK}};
            active_q     <= {N_DIGITS{SEG_BLANK}};
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign AN        = an_q;
    assign SEG       = seg_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with a small frame (4 digits, 8 cycles per
// slot, 2 gap cycles). A frame-position model predicts every output each
// cycle; directed scenarios pin the model with literal expectations,
// then randomized traffic exercises loads, masks, enable drops and resets.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int S     = 8;
    localparam int G     = 2;
    localparam int FRAME = N * S;

    localparam logic [7*N-1:0] PAT_A = {7'b1111000, 7'b0110000, 7'b0100100, 7'b1111001};
    localparam logic [7*N-1:0] PAT_B = {7'b0000000, 7'b0000010, 7'b0010010, 7'b0011001};
    localparam logic [7*N-1:0] PAT_C = {7'b0000110, 7'b1000110, 7'b0001000, 7'b1000000};
    localparam logic [7*N-1:0] PAT_D = {7'b0001110, 7'b0100001, 7'b0000011, 7'b0010010};

    logic           clk;
    logic           rst_n = 1'b1;
    logic [7*N-1:0] seg_in;
    logic           load;
    logic [N-1:0]   blank_mask;
    logic           en;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           frame_done;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    seg_scan_driver #(
        .N_DIGITS (N),
        .SCAN_DIV (S),
        .GAP_CYC  (G)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .segIn     (seg_in),
        .load      (load),
        .blankMask (blank_mask),
        .en        (en),
        .AN        (an),
        .SEG       (seg),
        .frameDone (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: position inside the frame plus both pattern buffers
    logic [6:0] m_shadow [N];
    logic [6:0] m_active [N];
    bit         m_pending = 1'b0;
    int         m_pos = 0;
    logic [N-1:0] exp_an  = '1;
    logic [6:0]   exp_seg = 7'h7F;
    logic         exp_fd  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic [7*N-1:0] pat,
                                 input logic [N-1:0] mask, input logic enable);
        load       = ld;
        seg_in     = pat;
        blank_mask = mask;
        en         = enable;
    endtask

    task automatic waitFrameDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic checkLit(input string name, input logic [N-1:0] want_an, input logic [6:0] want_seg);
        checkOutput({name, "_an"}, 32'(an), 32'(want_an));
        checkOutput({name, "_seg"}, 32'(seg), 32'(want_seg));
    endtask

    // Behavioural model: one frame-position counter decides digit and phase, buffers follow the load rules
    always @(posedge clk or negedge rst_n) begin : model
        logic [6:0] newp [N];
        int d, c;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 7'h7F;
                m_active[i] = 7'h7F;
            end
            m_pending = 1'b0;
            m_pos     = 0;
            exp_an    = '1;
            exp_seg   = 7'h7F;
            exp_fd    = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) newp[i] = seg_in[7*i +: 7];
            if (!en) begin
                exp_an  = '1;
                exp_seg = 7'h7F;
                exp_fd  = 1'b0;
                for (int i = 0; i < N; i++) m_active[i] = load ? newp[i] : m_shadow[i];
                m_pending = 1'b0;
                m_pos     = 0;
            end else begin
                d = m_pos / S;
                c = m_pos % S;
                if (c >= G && !blank_mask[d]) begin
                    exp_an  = ~(4'b0001 << d);
                    exp_seg = m_active[d];
                end else begin
                    exp_an  = '1;
                    exp_seg = 7'h7F;
                end
                exp_fd = (m_pos == FRAME - 1);
                if (m_pos == FRAME - 1) begin
                    if (load) begin
                        for (int i = 0; i < N; i++) m_active[i] = newp[i];
                    end else if (m_pending) begin
                        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
                    end
                    m_pending = 1'b0;
                end else if (load) begin
                    m_pending = 1'b1;
                end
                m_pos = (m_pos + 1) % FRAME;
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_shadow[i] = newp[i];
            end
        end
    end

    // Every cycle, compare the registered outputs against the model away from the clock edge
    always @(negedge clk) begin
        checkOutput("scan_outputs", 32'({an, seg, frame_done}), 32'({exp_an, exp_seg, exp_fd}));
    end

    initial begin
        bit fd_seen;
        applyStimulus(1'b0, '0, '0, 1'b0);
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkLit("reset", 4'b1111, 7'h7F);
        checkOutput("reset_fd", 32'(frame_done), 32'd0);

        // Basic scan: load pattern A, it appears from the next frame
        rst_n = 1'b1;
        applyStimulus(1'b1, PAT_A, '0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, PAT_A, '0, 1'b1);
        waitFrameDone("basic_frame_start");
        repeat (2) @(negedge clk);
        checkLit("basic_gap", 4'b1111, 7'h7F);
        repeat (1) @(negedge clk);
        checkLit("basic_d0", 4'b1110, 7'b1111001);
        repeat (8) @(negedge clk);
        checkLit("basic_d1", 4'b1101, 7'b0100100);
        repeat (8) @(negedge clk);
        checkLit("basic_d2", 4'b1011, 7'b0110000);
        repeat (8) @(negedge clk);
        checkLit("basic_d3", 4'b0111, 7'b1111000);
        repeat (4) @(negedge clk);
        checkOutput("basic_fd_low", 32'(frame_done), 32'd0);
        repeat (1) @(negedge clk);
        checkOutput("basic_fd_period", 32'(frame_done), 32'd1);

        // Tear-free load while digit 1 is lit
        repeat (12) @(negedge clk);
        applyStimulus(1'b1, PAT_B, '0, 1'b1);
        repeat (1) @(negedge clk);
        applyStimulus(1'b0, PAT_B, '0, 1'b1);
        repeat (6) @(negedge clk);
        checkLit("tear_d2_old", 4'b1011, 7'b0110000);
        repeat (8) @(negedge clk);
        checkLit("tear_d3_old", 4'b0111, 7'b1111000);
        repeat (8) @(negedge clk);
        checkLit("tear_d0_new", 4'b1110, 7'b0011001);
        repeat (16) @(negedge clk);
        checkLit("tear_d2_new", 4'b1011, 7'b0000010);

        // Load coinciding with the frame boundary cycle
        waitFrameDone("coinc_frame_start");
        repeat (31) @(negedge clk);
        applyStimulus(1'b1, PAT_C, '0, 1'b1);
        repeat (1) @(negedge clk);
        applyStimulus(1'b0, PAT_B, '0, 1'b1);
        checkOutput("coinc_fd", 32'(frame_done), 32'd1);
        repeat (3) @(negedge clk);
        checkLit("coinc_d0", 4'b1110, 7'b1000000);

        // Mask digit 2 for one frame
        waitFrameDone("mask_frame_start");
        applyStimulus(1'b0, PAT_B, 4'b0100, 1'b1);
        repeat (11) @(negedge clk);
        checkLit("mask_d1", 4'b1101, 7'b0001000);
        repeat (8) @(negedge clk);
        checkLit("mask_d2_first", 4'b1111, 7'h7F);
        repeat (5) @(negedge clk);
        checkLit("mask_d2_last", 4'b1111, 7'h7F);
        repeat (3) @(negedge clk);
        checkLit("mask_d3", 4'b0111, 7'b0000110);
        applyStimulus(1'b0, PAT_B, '0, 1'b1);

        // Enable drop mid-frame with a load while idle
        waitFrameDone("endrop_frame_start");
        repeat (10) @(negedge clk);
        applyStimulus(1'b1, PAT_D, '0, 1'b0);
        repeat (1) @(negedge clk);
        applyStimulus(1'b0, PAT_A, '0, 1'b0);
        checkLit("endrop_blank", 4'b1111, 7'h7F);
        fd_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            fd_seen |= frame_done;
        end
        checkOutput("endrop_no_fd", 32'(fd_seen), 32'd0);
        applyStimulus(1'b0, PAT_A, '0, 1'b1);
        repeat (2) @(negedge clk);
        checkLit("enresume_gap", 4'b1111, 7'h7F);
        repeat (1) @(negedge clk);
        checkLit("enresume_d0", 4'b1110, 7'b0010010);

        // Asynchronous reset while digit 0 is lit
        #2 rst_n = 1'b0;
        #1;
        checkLit("rst_async", 4'b1111, 7'h7F);
        checkOutput("rst_async_fd", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkLit("rst_restart_gap", 4'b1111, 7'h7F);
        repeat (1) @(negedge clk);
        checkLit("rst_restart_d0", 4'b1110, 7'h7F);

        // Randomized traffic checked by the model
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load       = ($urandom_range(0, 9) == 0);
            seg_in     = 28'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
